// File: rtl/wb_commit_unit.sv
// rtl/wb_commit_unit.sv - write-back commit: GPR write port, HI/LO, forwarding record (optional WB_RETIRE_CNT_EN commit counter)
module wb_commit_unit #(
    parameter int          DATA_W   = 32,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  MemToRegIn,
    input  logic [DATA_W-1:0]     LoadDataIn,
    input  logic [DATA_W-1:0]     ALUResultIn,
    input  logic [2*DATA_W-1:0]   ALU64ResultIn,
    input  logic [DATA_W-1:0]     PC4In,
    input  logic                  RegWriteIn,
    input  logic                  LinkIn,
    input  logic [1:0]            RegDstIn,
    input  logic [4:0]            RtIn,
    input  logic [4:0]            RdIn,
    input  logic                  HiSrcIn,
    input  logic                  LoSrcIn,
    input  logic                  HiWriteIn,
    input  logic                  LoWriteIn,
    output logic                  RegWriteOut,
    output logic [4:0]            WriteRegOut,
    output logic [DATA_W-1:0]     WriteDataOut,
    output logic [DATA_W-1:0]     HiOut,
    output logic [DATA_W-1:0]     LoOut,
    output logic                  FwdValidOut,
    output logic [4:0]            FwdRegOut,
    output logic [DATA_W-1:0]     FwdDataOut
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]           RetireCountOut
`endif
);

    logic [DATA_W-1:0] hiReg;
    logic [DATA_W-1:0] loReg;
    logic              fwdValid;
    logic [4:0]        fwdReg;
    logic [DATA_W-1:0] fwdData;

    // Destination index, write data and effective write enable (zero latency)
    always_comb begin
        WriteRegOut = RtIn;
        case (RegDstIn)
            2'b00:   WriteRegOut = RtIn;
            2'b01:   WriteRegOut = RdIn;
            2'b10:   WriteRegOut = LINK_REG;
            default: WriteRegOut = RtIn;
        endcase

        WriteDataOut = ALUResultIn;
        if (LinkIn)
            WriteDataOut = PC4In;
        else if (MemToRegIn)
            WriteDataOut = LoadDataIn;

        // Reserved destination and $0 are dropped; no writes while in reset
        RegWriteOut = Reset_n & RegWriteIn & (RegDstIn != 2'b11) & (WriteRegOut != 5'd0);
    end

    // Architectural HI register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            hiReg <= '0;
        else if (HiWriteIn)
            hiReg <= HiSrcIn ? ALUResultIn : ALU64ResultIn[2*DATA_W-1:DATA_W];
    end

    // Architectural LO register, independent of HI
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            loReg <= '0;
        else if (LoWriteIn)
            loReg <= LoSrcIn ? ALUResultIn : ALU64ResultIn[DATA_W-1:0];
    end

    // One-cycle forwarding record; index/data hold when no commit, only valid clears
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fwdValid <= 1'b0;
            fwdReg   <= '0;
            fwdData  <= '0;
        end else begin
            fwdValid <= RegWriteOut;
            if (RegWriteOut) begin
                fwdReg  <= WriteRegOut;
                fwdData <= WriteDataOut;
            end
        end
    end

    assign HiOut       = hiReg;
    assign LoOut       = loReg;
    assign FwdValidOut = fwdValid;
    assign FwdRegOut   = fwdReg;
    assign FwdDataOut  = fwdData;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retireCount;

    // Count commits once regardless of how many targets they write; wraps silently
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            retireCount <= '0;
        else if (RegWriteOut | HiWriteIn | LoWriteIn)
            retireCount <= retireCount + 32'd1;
    end

    assign RetireCountOut = retireCount;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// tb/tb_wb_commit_unit.sv - directed self-checking bench for wb_commit_unit
module tb_wb_commit_unit;

    logic        Clk;
    logic        Reset_n;
    logic        MemToRegIn;
    logic [31:0] LoadDataIn;
    logic [31:0] ALUResultIn;
    logic [63:0] ALU64ResultIn;
    logic [31:0] PC4In;
    logic        RegWriteIn;
    logic        LinkIn;
    logic [1:0]  RegDstIn;
    logic [4:0]  RtIn;
    logic [4:0]  RdIn;
    logic        HiSrcIn;
    logic        LoSrcIn;
    logic        HiWriteIn;
    logic        LoWriteIn;
    logic        RegWriteOut;
    logic [4:0]  WriteRegOut;
    logic [31:0] WriteDataOut;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        FwdValidOut;
    logic [4:0]  FwdRegOut;
    logic [31:0] FwdDataOut;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] RetireCountOut;
`endif

    int errors = 0;
    int checks = 0;

    wb_commit_unit #(.DATA_W(32), .LINK_REG(5'd31)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .MemToRegIn    (MemToRegIn),
        .LoadDataIn    (LoadDataIn),
        .ALUResultIn   (ALUResultIn),
        .ALU64ResultIn (ALU64ResultIn),
        .PC4In         (PC4In),
        .RegWriteIn    (RegWriteIn),
        .LinkIn        (LinkIn),
        .RegDstIn      (RegDstIn),
        .RtIn          (RtIn),
        .RdIn          (RdIn),
        .HiSrcIn       (HiSrcIn),
        .LoSrcIn       (LoSrcIn),
        .HiWriteIn     (HiWriteIn),
        .LoWriteIn     (LoWriteIn),
        .RegWriteOut   (RegWriteOut),
        .WriteRegOut   (WriteRegOut),
        .WriteDataOut  (WriteDataOut),
        .HiOut         (HiOut),
        .LoOut         (LoOut),
        .FwdValidOut   (FwdValidOut),
        .FwdRegOut     (FwdRegOut),
        .FwdDataOut    (FwdDataOut)
`ifdef WB_RETIRE_CNT_EN
        ,
        .RetireCountOut(RetireCountOut)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic idle_inputs();
        MemToRegIn    = 1'b0;
        LoadDataIn    = 32'h0;
        ALUResultIn   = 32'h0;
        ALU64ResultIn = 64'h0;
        PC4In         = 32'h0;
        RegWriteIn    = 1'b0;
        LinkIn        = 1'b0;
        RegDstIn      = 2'b00;
        RtIn          = 5'd0;
        RdIn          = 5'd0;
        HiSrcIn       = 1'b0;
        LoSrcIn       = 1'b0;
        HiWriteIn     = 1'b0;
        LoWriteIn     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset_n       = 1'b0;
        RegWriteIn    = 1'b1;
        HiWriteIn     = 1'b1;
        LoWriteIn     = 1'b1;
        RegDstIn      = 2'b00;
        RtIn          = 5'd5;
        ALUResultIn   = 32'h1234_5678;
        ALU64ResultIn = 64'h1111_2222_3333_4444;
        #1;
        checks++;
        if (RegWriteOut !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", RegWriteOut); end
        checks++;
        if (WriteRegOut !== 5'd5) begin errors++; $display("FAIL reset_writereg_follows got %0d exp 5", WriteRegOut); end
        checks++;
        if (WriteDataOut !== 32'h1234_5678) begin errors++; $display("FAIL reset_writedata_follows got %h exp 12345678", WriteDataOut); end
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            checks++;
            if (HiOut !== 32'h0 || LoOut !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h/%h exp 0/0", HiOut, LoOut); end
            checks++;
            if (FwdValidOut !== 1'b0 || FwdRegOut !== 5'd0 || FwdDataOut !== 32'h0) begin
                errors++; $display("FAIL reset_fwd got %b/%0d/%h exp 0/0/0", FwdValidOut, FwdRegOut, FwdDataOut);
            end
`ifdef WB_RETIRE_CNT_EN
            checks++;
            if (RetireCountOut !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp 0", RetireCountOut); end
`endif
        end
        @(negedge Clk);
        idle_inputs();
        Reset_n = 1'b1;
    endtask

    task automatic test_wb_mux();
        @(negedge Clk);
        idle_inputs();
        RegWriteIn  = 1'b1;
        MemToRegIn  = 1'b1;
        LoadDataIn  = 32'hDEAD_BEEF;
        ALUResultIn = 32'h0000_0055;
        RegDstIn    = 2'b01;
        RdIn        = 5'd8;
        RtIn        = 5'd9;
        #1;
        checks++;
        if (RegWriteOut !== 1'b1 || WriteRegOut !== 5'd8 || WriteDataOut !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wb_mux_load got %b/%0d/%h exp 1/8/deadbeef", RegWriteOut, WriteRegOut, WriteDataOut);
        end
        MemToRegIn = 1'b0;
        #1;
        checks++;
        if (WriteDataOut !== 32'h0000_0055) begin errors++; $display("FAIL wb_mux_alu got %h exp 00000055", WriteDataOut); end
        MemToRegIn = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (FwdValidOut !== 1'b1 || FwdRegOut !== 5'd8 || FwdDataOut !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wb_mux_fwd got %b/%0d/%h exp 1/8/deadbeef", FwdValidOut, FwdRegOut, FwdDataOut);
        end
        @(negedge Clk);
        idle_inputs();
        @(posedge Clk); #1;
        checks++;
        if (FwdValidOut !== 1'b0 || FwdRegOut !== 5'd8 || FwdDataOut !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wb_mux_fwd_clear got %b/%0d/%h exp 0/8/deadbeef", FwdValidOut, FwdRegOut, FwdDataOut);
        end
    endtask

    task automatic test_link();
        @(negedge Clk);
        idle_inputs();
        RegWriteIn  = 1'b1;
        LinkIn      = 1'b1;
        MemToRegIn  = 1'b1;
        LoadDataIn  = 32'hDEAD_BEEF;
        ALUResultIn = 32'h0000_0077;
        PC4In       = 32'h0040_0010;
        RegDstIn    = 2'b10;
        RtIn        = 5'd3;
        RdIn        = 5'd4;
        #1;
        checks++;
        if (RegWriteOut !== 1'b1 || WriteRegOut !== 5'd31 || WriteDataOut !== 32'h0040_0010) begin
            errors++; $display("FAIL link got %b/%0d/%h exp 1/31/00400010", RegWriteOut, WriteRegOut, WriteDataOut);
        end
        @(posedge Clk); #1;
        checks++;
        if (FwdValidOut !== 1'b1 || FwdRegOut !== 5'd31 || FwdDataOut !== 32'h0040_0010) begin
            errors++; $display("FAIL link_fwd got %b/%0d/%h exp 1/31/00400010", FwdValidOut, FwdRegOut, FwdDataOut);
        end
    endtask

    task automatic test_zero_reserved();
        @(negedge Clk);
        idle_inputs();
        RegWriteIn  = 1'b1;
        ALUResultIn = 32'hCAFE_0001;
        RegDstIn    = 2'b00;
        RtIn        = 5'd0;
        RdIn        = 5'd7;
        #1;
        checks++;
        if (RegWriteOut !== 1'b0 || WriteRegOut !== 5'd0) begin
            errors++; $display("FAIL zero_reg got %b/%0d exp 0/0", RegWriteOut, WriteRegOut);
        end
        @(posedge Clk); #1;
        checks++;
        if (FwdValidOut !== 1'b0) begin errors++; $display("FAIL zero_reg_fwd got %b exp 0", FwdValidOut); end
        @(negedge Clk);
        RegDstIn = 2'b11;
        RtIn     = 5'd5;
        #1;
        checks++;
        if (RegWriteOut !== 1'b0 || WriteRegOut !== 5'd5) begin
            errors++; $display("FAIL reserved_dst got %b/%0d exp 0/5", RegWriteOut, WriteRegOut);
        end
        @(posedge Clk); #1;
        checks++;
        if (FwdValidOut !== 1'b0 || FwdRegOut !== 5'd31 || FwdDataOut !== 32'h0040_0010) begin
            errors++; $display("FAIL reserved_fwd_hold got %b/%0d/%h exp 0/31/00400010", FwdValidOut, FwdRegOut, FwdDataOut);
        end
    endtask

    task automatic test_hilo();
        @(negedge Clk);
        idle_inputs();
        HiWriteIn     = 1'b1;
        LoWriteIn     = 1'b1;
        ALU64ResultIn = 64'h0000_0001_FFFF_FFFE;
        ALUResultIn   = 32'h0000_0099;
        #1;
        checks++;
        if (HiOut !== 32'h0 || LoOut !== 32'h0) begin errors++; $display("FAIL hilo_same_cycle_old got %h/%h exp 0/0", HiOut, LoOut); end
        @(posedge Clk); #1;
        checks++;
        if (HiOut !== 32'h0000_0001 || LoOut !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL hilo_mult got %h/%h exp 00000001/fffffffe", HiOut, LoOut);
        end
        @(negedge Clk);
        idle_inputs();
        HiWriteIn     = 1'b1;
        HiSrcIn       = 1'b1;
        ALUResultIn   = 32'h0000_0007;
        ALU64ResultIn = 64'h5555_5555_6666_6666;
        @(posedge Clk); #1;
        checks++;
        if (HiOut !== 32'h0000_0007 || LoOut !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL hilo_mthi got %h/%h exp 00000007/fffffffe", HiOut, LoOut);
        end
        @(negedge Clk);
        idle_inputs();
        LoWriteIn     = 1'b1;
        LoSrcIn       = 1'b1;
        ALUResultIn   = 32'h0000_1234;
        ALU64ResultIn = 64'h7777_7777_8888_8888;
        @(posedge Clk); #1;
        checks++;
        if (HiOut !== 32'h0000_0007 || LoOut !== 32'h0000_1234) begin
            errors++; $display("FAIL hilo_mtlo got %h/%h exp 00000007/00001234", HiOut, LoOut);
        end
        @(negedge Clk);
        idle_inputs();
        ALU64ResultIn = 64'h9999_9999_AAAA_AAAA;
        @(posedge Clk); #1;
        checks++;
        if (HiOut !== 32'h0000_0007 || LoOut !== 32'h0000_1234) begin
            errors++; $display("FAIL hilo_hold got %h/%h exp 00000007/00001234", HiOut, LoOut);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge Clk);
        idle_inputs();
        RegWriteIn    = 1'b1;
        RegDstIn      = 2'b01;
        RdIn          = 5'd3;
        ALUResultIn   = 32'h0000_0011;
        HiWriteIn     = 1'b1;
        ALU64ResultIn = 64'hABCD_0000_0000_0000;
        @(posedge Clk); #1;
        checks++;
        if (FwdValidOut !== 1'b1 || FwdRegOut !== 5'd3 || FwdDataOut !== 32'h0000_0011) begin
            errors++; $display("FAIL b2b_first got %b/%0d/%h exp 1/3/00000011", FwdValidOut, FwdRegOut, FwdDataOut);
        end
        checks++;
        if (HiOut !== 32'hABCD_0000) begin errors++; $display("FAIL b2b_hi_with_gpr got %h exp abcd0000", HiOut); end
        @(negedge Clk);
        idle_inputs();
        RegWriteIn = 1'b1;
        RegDstIn   = 2'b00;
        RtIn       = 5'd4;
        MemToRegIn = 1'b1;
        LoadDataIn = 32'h0000_0022;
        @(posedge Clk); #1;
        checks++;
        if (FwdValidOut !== 1'b1 || FwdRegOut !== 5'd4 || FwdDataOut !== 32'h0000_0022) begin
            errors++; $display("FAIL b2b_second got %b/%0d/%h exp 1/4/00000022", FwdValidOut, FwdRegOut, FwdDataOut);
        end
        @(negedge Clk);
        idle_inputs();
    endtask

    task automatic test_async_reset();
        @(negedge Clk);
        idle_inputs();
        RegWriteIn  = 1'b1;
        RegDstIn    = 2'b01;
        RdIn        = 5'd12;
        ALUResultIn = 32'h0BAD_F00D;
        LoWriteIn   = 1'b1;
        LoSrcIn     = 1'b1;
        @(posedge Clk); #3;
        HiWriteIn     = 1'b1;
        ALU64ResultIn = 64'hAAAA_AAAA_BBBB_BBBB;
        Reset_n       = 1'b0;
        #1;
        checks++;
        if (FwdValidOut !== 1'b0 || FwdRegOut !== 5'd0 || FwdDataOut !== 32'h0) begin
            errors++; $display("FAIL async_reset_fwd got %b/%0d/%h exp 0/0/0", FwdValidOut, FwdRegOut, FwdDataOut);
        end
        checks++;
        if (HiOut !== 32'h0 || LoOut !== 32'h0 || RegWriteOut !== 1'b0) begin
            errors++; $display("FAIL async_reset_hilo got %h/%h/%b exp 0/0/0", HiOut, LoOut, RegWriteOut);
        end
        @(posedge Clk); #1;
        checks++;
        if (HiOut !== 32'h0 || LoOut !== 32'h0) begin errors++; $display("FAIL async_reset_pending got %h/%h exp 0/0", HiOut, LoOut); end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (HiOut !== 32'hAAAA_AAAA || LoOut !== 32'h0BAD_F00D || FwdValidOut !== 1'b1 || FwdRegOut !== 5'd12) begin
            errors++; $display("FAIL async_reset_resume got %h/%h/%b/%0d exp aaaaaaaa/0badf00d/1/12", HiOut, LoOut, FwdValidOut, FwdRegOut);
        end
        @(negedge Clk);
        idle_inputs();
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_counter();
        @(negedge Clk);
        idle_inputs();
        force dut.retireCount = 32'hFFFF_FFFF;
        #1;
        release dut.retireCount;
        RegWriteIn  = 1'b1;
        RegDstIn    = 2'b01;
        RdIn        = 5'd2;
        ALUResultIn = 32'h1;
        HiWriteIn   = 1'b1;
        LoWriteIn   = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (RetireCountOut !== 32'h0) begin errors++; $display("FAIL count_wrap got %h exp 0", RetireCountOut); end
        @(negedge Clk);
        idle_inputs();
        RegWriteIn = 1'b1;
        RtIn       = 5'd0;
        @(posedge Clk); #1;
        checks++;
        if (RetireCountOut !== 32'h0) begin errors++; $display("FAIL count_suppressed got %h exp 0", RetireCountOut); end
        @(negedge Clk);
        idle_inputs();
        LoWriteIn = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (RetireCountOut !== 32'h1) begin errors++; $display("FAIL count_lo_only got %h exp 1", RetireCountOut); end
        @(negedge Clk);
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_wb_mux();
        test_link();
        test_zero_reserved();
        test_hilo();
        test_back_to_back();
        test_async_reset();
`ifdef WB_RETIRE_CNT_EN
        test_counter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
